// File: rtl/mask_gen_arbiter.sv
// mask_gen_arbiter
// Shares one 512-bit mask generator among NREQ requesters using a round-robin
// grant. Drives the generator's trig/done handshake, captures the finished
// mask and returns it to the winner. A watchdog aborts a stuck transaction.
//
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_req[NREQ]              request level per requester (held until o_ack)
//   i_left_or_right[NREQ]    direction per requester (0=left, 1=right)
//   i_bound_index[9*NREQ]    bound index per requester, k at [9k+8:9k]
//   o_ack[NREQ]              done strobe to the granted requester
//   o_mask[512]              result mask, zero unless an ack is high
//   o_err                    ack carries a timed-out result
//   o_gnt_id[3]              id of the current/last grant
//   o_mg_trig                trigger to the mask generator
//   o_mg_left_or_right       direction to the mask generator
//   o_mg_bound_index[9]      bound index to the mask generator
//   i_mg_done, i_mg_mask     generator completion and result
module mask_gen_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [NREQ-1:0]     i_req,
    input  logic [NREQ-1:0]     i_left_or_right,
    input  logic [9*NREQ-1:0]   i_bound_index,
    output logic [NREQ-1:0]     o_ack,
    output logic [511:0]        o_mask,
    output logic                o_err,
    output logic [2:0]          o_gnt_id,
    output logic                o_mg_trig,
    output logic                o_mg_left_or_right,
    output logic [8:0]          o_mg_bound_index,
    input  logic                i_mg_done,
    input  logic [511:0]        i_mg_mask
);

    localparam int unsigned IDW = 3;
    localparam int unsigned BIW = 9;
    localparam int unsigned MW  = 512;
    localparam int unsigned WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_gnt_id,   w_gnt_id_nxt;
    logic [IDW-1:0]     r_last_gnt, w_last_gnt_nxt;
    logic               r_trig,     w_trig_nxt;
    logic               r_dir,      w_dir_nxt;
    logic [BIW-1:0]     r_idx,      w_idx_nxt;
    logic [MW-1:0]      r_mask,     w_mask_nxt;
    logic               r_err,      w_err_nxt;
    logic [WDW-1:0]     r_wd,       w_wd_nxt;

    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic               w_win_dir;
    logic [BIW-1:0]     w_win_idx;
    logic               w_gnt_req;
    logic [NREQ-1:0]    w_gnt_onehot;
    logic               w_ack_hit;

    // Round-robin pick: smallest distance past the last grant wins
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        w_found = 1'b0;
        w_win   = '0;
        best_d  = NREQ;
        d       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            d = (k + NREQ - 1 - 32'(r_last_gnt)) % NREQ;
            if (i_req[k] && (d < best_d)) begin
                best_d  = d;
                w_win   = IDW'(k);
                w_found = 1'b1;
            end
        end
    end

    // Winner's direction and index, sampled only when the grant is taken
    always_comb begin
        w_win_dir = 1'b0;
        w_win_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == w_win) begin
                w_win_dir = i_left_or_right[k];
                w_win_idx = i_bound_index[BIW*k +: BIW];
            end
        end
    end

    // Request level and one-hot of the current grant
    always_comb begin
        w_gnt_req    = 1'b0;
        w_gnt_onehot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == r_gnt_id) begin
                w_gnt_req       = i_req[k];
                w_gnt_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state and register updates
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_id_nxt   = r_gnt_id;
        w_last_gnt_nxt = r_last_gnt;
        w_trig_nxt     = r_trig;
        w_dir_nxt      = r_dir;
        w_idx_nxt      = r_idx;
        w_mask_nxt     = r_mask;
        w_err_nxt      = r_err;
        w_wd_nxt       = r_wd;
        case (r_state)
            S_IDLE: begin
                w_trig_nxt = 1'b0;
                if (w_found) begin
                    w_gnt_id_nxt   = w_win;
                    w_last_gnt_nxt = w_win;
                    w_dir_nxt      = w_win_dir;
                    w_idx_nxt      = w_win_idx;
                    w_trig_nxt     = 1'b1;
                    w_wd_nxt       = '0;
                    w_state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_trig_nxt = 1'b1;
                w_wd_nxt   = r_wd + WDW'(1);
                if (i_mg_done) begin
                    w_mask_nxt  = i_mg_mask;
                    w_err_nxt   = 1'b0;
                    w_trig_nxt  = 1'b0;
                    w_state_nxt = S_RESP;
                end else if (r_wd == WD_LAST) begin
                    w_mask_nxt  = '0;
                    w_err_nxt   = 1'b1;
                    w_trig_nxt  = 1'b0;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_trig_nxt = 1'b0;
                if (!w_gnt_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_trig_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers; last grant resets so requester 0 goes first
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_gnt_id   <= '0;
            r_last_gnt <= IDW'(NREQ - 1);
            r_trig     <= 1'b0;
            r_dir      <= 1'b0;
            r_idx      <= '0;
            r_mask     <= '0;
            r_err      <= 1'b0;
            r_wd       <= '0;
        end else begin
            r_gnt_id   <= w_gnt_id_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_trig     <= w_trig_nxt;
            r_dir      <= w_dir_nxt;
            r_idx      <= w_idx_nxt;
            r_mask     <= w_mask_nxt;
            r_err      <= w_err_nxt;
            r_wd       <= w_wd_nxt;
        end
    end

    // Ack follows the winner's request live so it drops in the same cycle
    assign o_ack     = ((r_state == S_RESP) && w_gnt_req) ? w_gnt_onehot : '0;
    assign w_ack_hit = |o_ack;
    assign o_mask    = w_ack_hit ? r_mask : '0;
    assign o_err     = r_err & w_ack_hit;

    assign o_gnt_id           = r_gnt_id;
    assign o_mg_trig          = r_trig;
    assign o_mg_left_or_right = r_dir;
    assign o_mg_bound_index   = r_idx;

endmodule

// File: tb/tb_mask_gen_arbiter.sv
// Testbench for mask_gen_arbiter: generator stub, round-robin reference model,
// scoreboard queue and a monitor that checks every ack presented by the DUT.
module tb_mask_gen_arbiter;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned TIMEOUT   = 32;
    localparam int          GEN_STEPS = 10;

    logic                i_clk = 1'b0;
    logic                i_rstn;
    logic [NREQ-1:0]     i_req;
    logic [NREQ-1:0]     i_left_or_right;
    logic [9*NREQ-1:0]   i_bound_index;
    logic [NREQ-1:0]     o_ack;
    logic [511:0]        o_mask;
    logic                o_err;
    logic [2:0]          o_gnt_id;
    logic                o_mg_trig;
    logic                o_mg_left_or_right;
    logic [8:0]          o_mg_bound_index;
    logic                i_mg_done;
    logic [511:0]        i_mg_mask;

    typedef struct {
        int           id;
        logic [511:0] mask;
        logic         err;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              m_last;
    logic [NREQ-1:0] auto_drop;
    logic            gen_hang;
    logic            drv_dir [NREQ];
    logic [8:0]      drv_idx [NREQ];
    int              gcnt;

    mask_gen_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk              (i_clk),
        .i_rstn             (i_rstn),
        .i_req              (i_req),
        .i_left_or_right    (i_left_or_right),
        .i_bound_index      (i_bound_index),
        .o_ack              (o_ack),
        .o_mask             (o_mask),
        .o_err              (o_err),
        .o_gnt_id           (o_gnt_id),
        .o_mg_trig          (o_mg_trig),
        .o_mg_left_or_right (o_mg_left_or_right),
        .o_mg_bound_index   (o_mg_bound_index),
        .i_mg_done          (i_mg_done),
        .i_mg_mask          (i_mg_mask)
    );

    always #5 i_clk = ~i_clk;

    // Left keeps bits at or above the index, right keeps bits below it
    function automatic logic [511:0] exp_mask(input logic dir, input logic [8:0] idx);
        logic [511:0] m;
        for (int i = 0; i < 512; i++) begin
            m[i] = dir ? (i < int'(idx)) : (i >= int'(idx));
        end
        return m;
    endfunction

    // Generator stub: done after GEN_STEPS cycles of trig, unless hung
    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                gcnt <= 0;
        else if (!o_mg_trig)        gcnt <= 0;
        else if (gcnt < GEN_STEPS)  gcnt <= gcnt + 1;
    end
    assign i_mg_done = o_mg_trig && (gcnt == GEN_STEPS) && !gen_hang;
    assign i_mg_mask = i_mg_done ? exp_mask(o_mg_left_or_right, o_mg_bound_index)
                                 : {16{32'hDEADBEEF}};

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: serve a set of simultaneous requests in round-robin order
    function automatic void push_order(input logic [NREQ-1:0] set);
        logic [NREQ-1:0] left;
        exp_t e;
        left = set;
        while (left != '0) begin
            for (int s = 1; s <= int'(NREQ); s++) begin
                int c;
                c = (m_last + s) % int'(NREQ);
                if (left[c]) begin
                    e.id   = c;
                    e.mask = exp_mask(drv_dir[c], drv_idx[c]);
                    e.err  = 1'b0;
                    sb.push_back(e);
                    left[c] = 1'b0;
                    m_last  = c;
                    break;
                end
            end
        end
    endfunction

    task automatic set_req(input int k, input logic dir, input logic [8:0] idx);
        drv_dir[k]                = dir;
        drv_idx[k]                = idx;
        i_left_or_right[k]        = dir;
        i_bound_index[9*k +: 9]   = idx;
        i_req[k]                  = 1'b1;
    endtask

    task automatic measure(input int k, output int t_trig, output int t_ack);
        t_trig = -1;
        t_ack  = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            if (o_mg_trig && t_trig < 0) t_trig = t;
            if (o_ack[k]) begin
                t_ack = t;
                break;
            end
        end
    endtask

    task automatic wait_trig(input string name);
        int n;
        n = 0;
        while (!o_mg_trig && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_mg_trig) begin
            checks++;
            errors++;
            $display("FAIL %s_trig_wait: trig never rose", name);
        end
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((i_req != '0 || sb.size() != 0) && n < max_cyc) begin
            @(negedge i_clk);
            n++;
        end
        if (i_req != '0 || sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: timed out req=%b pending=%0d", name, i_req, sb.size());
        end
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_trig"},  512'(o_mg_trig), 512'(0));
        chk({tag, "_ack"},   512'(o_ack), 512'(0));
        chk({tag, "_mask"},  o_mask, 512'(0));
        chk({tag, "_err"},   512'(o_err), 512'(0));
        chk({tag, "_gnt"},   512'(o_gnt_id), 512'(0));
        chk({tag, "_dir"},   512'(o_mg_left_or_right), 512'(0));
        chk({tag, "_index"}, 512'(o_mg_bound_index), 512'(0));
    endtask

    // Requester agent: drop request one cycle after its ack is seen
    initial begin : agent
        logic [NREQ-1:0] drop;
        forever begin
            @(negedge i_clk);
            drop = o_ack & auto_drop;
            if (drop != '0) begin
                @(posedge i_clk);
                #1;
                i_req = i_req & ~drop;
            end
        end
    end

    // Monitor: invariants each cycle, scoreboard compare on each new ack
    initial begin : monitor
        logic [NREQ-1:0] prev_ack;
        logic [NREQ-1:0] oh;
        exp_t            e;
        prev_ack = '0;
        forever begin
            @(negedge i_clk);
            checks++;
            if (((o_ack & ~i_req) != '0) || ($countones(o_ack) > 1) ||
                ((o_ack == '0) && ((o_mask != '0) || o_err))) begin
                errors++;
                $display("FAIL invariant: ack=%b req=%b err=%b mask_nonzero=%b",
                         o_ack, i_req, o_err, (o_mask != '0));
            end
            if (o_ack != '0 && prev_ack == '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack=%b expected none", o_ack);
                end else begin
                    e  = sb.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("mon_ack",  512'(o_ack), 512'(oh));
                    chk("mon_gnt",  512'(o_gnt_id), 512'(e.id));
                    chk("mon_mask", o_mask, e.mask);
                    chk("mon_err",  512'(o_err), 512'(e.err));
                end
            end
            prev_ack = o_ack;
        end
    end

    initial begin : global_guard
        #1000000;
        errors++;
        $display("FAIL global_timeout: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int tt, ta, th, ack_cnt;
        i_rstn          = 1'b0;
        i_req           = '0;
        i_left_or_right = '0;
        i_bound_index   = '0;
        auto_drop       = '1;
        gen_hang        = 1'b0;
        m_last          = int'(NREQ) - 1;
        for (int k = 0; k < int'(NREQ); k++) begin
            drv_dir[k] = 1'b0;
            drv_idx[k] = '0;
        end
        repeat (3) @(negedge i_clk);
        check_reset("reset");
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        repeat (2) @(posedge i_clk); #1;

        // Single left request, manual drop
        auto_drop[0] = 1'b0;
        set_req(0, 1'b0, 9'h100);
        push_order(4'b0001);
        measure(0, tt, ta);
        chk("left_trig_lat", 512'(tt), 512'(1));
        chk("left_ack_lat",  512'(ta), 512'(12));
        chk("left_mask_literal", o_mask, {{256{1'b1}}, {256{1'b0}}});
        @(posedge i_clk); #1;
        i_req[0] = 1'b0;
        #1;
        chk("left_drop_ack",  512'(o_ack), 512'(0));
        chk("left_drop_mask", o_mask, 512'(0));
        auto_drop[0] = 1'b1;
        drain(50, "left");

        // Right request from requester 2
        set_req(2, 1'b1, 9'h003);
        push_order(4'b0100);
        measure(2, tt, ta);
        chk("right_ack_lat", 512'(ta), 512'(12));
        chk("right_ack_vec", 512'(o_ack), 512'(4'b0100));
        chk("right_gnt",     512'(o_gnt_id), 512'(2));
        chk("right_mask",    o_mask, 512'h7);
        drain(100, "right");

        // Round-robin: all four requesting out of reset
        i_rstn = 1'b0;
        m_last = int'(NREQ) - 1;
        for (int k = 0; k < int'(NREQ); k++) set_req(k, k[0], 9'(40 * k + 7));
        push_order(4'b1111);
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        measure(0, tt, ta);
        chk("rr_first_ack_lat", 512'(ta), 512'(12));
        drain(400, "rr_all");
        set_req(0, 1'b1, 9'h1FF);
        set_req(2, 1'b0, 9'h001);
        push_order(4'b0101);
        drain(200, "rr_pair");

        // Randomized simultaneous request sets
        for (int it = 0; it < 20; it++) begin
            logic [NREQ-1:0] set;
            set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int k = 0; k < int'(NREQ); k++) begin
                if (set[k]) set_req(k, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
            end
            push_order(set);
            drain(1000, "random");
        end

        // Early drop: requester 1 abandons during ISSUE, no ack
        auto_drop[1] = 1'b0;
        set_req(1, 1'b1, 9'h0C0);
        m_last = 1;
        wait_trig("early");
        repeat (3) @(posedge i_clk); #1;
        i_req[1] = 1'b0;
        ack_cnt = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_ack != '0) ack_cnt++;
        end
        chk("early_no_ack",    512'(ack_cnt), 512'(0));
        chk("early_trig_idle", 512'(o_mg_trig), 512'(0));
        auto_drop[1] = 1'b1;
        @(posedge i_clk); #1;
        set_req(3, 1'b0, 9'h020);
        push_order(4'b1000);
        measure(3, tt, ta);
        chk("after_early_ack_lat", 512'(ta), 512'(12));
        drain(100, "after_early");

        // Timeout: generator never completes
        gen_hang = 1'b1;
        begin
            exp_t e;
            set_req(1, 1'b0, 9'h0AA);
            e.id = 1; e.mask = '0; e.err = 1'b1;
            sb.push_back(e);
            m_last = 1;
        end
        wait_trig("timeout");
        th = 1;
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            if (!o_mg_trig) break;
            th++;
        end
        chk("timeout_trig_cycles", 512'(th), 512'(TIMEOUT));
        chk("timeout_ack",  512'(o_ack), 512'(4'b0010));
        chk("timeout_err",  512'(o_err), 512'(1));
        chk("timeout_mask", o_mask, 512'(0));
        gen_hang = 1'b0;
        drain(100, "timeout");

        // Reset mid-ISSUE: pointer returns to requester-0 priority
        set_req(0, 1'b1, 9'h1F0);
        push_order(4'b0001);
        drain(100, "pre_reset");
        set_req(1, 1'b1, 9'h155);
        set_req(3, 1'b0, 9'h0F3);
        wait_trig("mid_reset");
        repeat (5) @(posedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        check_reset("mid_reset");
        sb.delete();
        m_last = int'(NREQ) - 1;
        @(negedge i_clk);
        i_rstn = 1'b1;
        push_order(4'b1010);
        drain(300, "post_reset");

        chk("scoreboard_empty", 512'(sb.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
